sram_controller: RTL and testbench

//  Memory-stage bridge between the 32-bit MEM-stage load/store request and the external 16-bit asynchronous SRAM.

---
 rtl/sram_controller_pkg.sv | 22 ++
 rtl/sram_controller_if.sv | 21 ++
 rtl/sram_controller.sv | 120 ++++++++++++
 tb/tb_sram_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM bridge: FSM encoding, SRAM bus
// widths and the CPU byte address to SRAM word mapping.
package sram_controller_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int WORD_W      = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    // Offset from the window base, in 32-bit words; byte-lane bits drop out in the shift.
    function automatic logic [WORD_W-1:0] sram_word(input logic [31:0] addr,
                                                    input logic [31:0] base);
        return WORD_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// CPU-side load/store request bundle between the MEM stage and the SRAM bridge.
interface sram_controller_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_ready;

    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, mem_ready
    );

    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, mem_ready
    );

endinterface

// File: rtl/sram_controller.sv
// Moves one 32-bit load/store as two timed 16-bit half accesses on an external
// asynchronous SRAM; mem_ready stalls the pipeline while an access is in flight.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_controller_if.slave       bus,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(ACCESS_CYCLES - 2);
    // A one-cycle half has no room for a WE_N gap, so the strobe then spans both halves.
    localparam bit GAP_EN = (ACCESS_CYCLES > 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   op_wr_q;
    logic [WORD_W-1:0]      word_q;
    logic [SRAM_DATA_W-1:0] wdata_hi_q;
    logic [31:0]            read_data_q;
    logic [SRAM_ADDR_W-1:0] sram_addr_q;
    logic                   we_n_q;
    logic [SRAM_DATA_W-1:0] dq_out_q;
    logic                   dq_oe_q;
    logic                   mem_ready_d;
    logic [WORD_W-1:0]      req_word;

    assign req_word = sram_word(bus.address, BASE_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.rd_en | bus.wr_en) begin
                        // A simultaneous rd_en/wr_en resolves to a write.
                        state_q     <= LOW;
                        cnt_q       <= '0;
                        op_wr_q     <= bus.wr_en;
                        word_q      <= req_word;
                        wdata_hi_q  <= bus.write_data[31:16];
                        sram_addr_q <= {req_word, 1'b0};
                        dq_out_q    <= bus.write_data[15:0];
                        dq_oe_q     <= bus.wr_en;
                        we_n_q      <= ~bus.wr_en;
                    end
                end
                LOW, HIGH: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (state_q == LOW) begin
                            if (!op_wr_q) read_data_q[15:0] <= SRAM_DQ;
                            state_q     <= HIGH;
                            sram_addr_q <= {word_q, 1'b1};
                            dq_out_q    <= wdata_hi_q;
                            we_n_q      <= ~op_wr_q;
                        end else begin
                            if (!op_wr_q) read_data_q[31:16] <= SRAM_DQ;
                            state_q <= DONE;
                            dq_oe_q <= 1'b0;
                            we_n_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Release WE_N for the last cycle of the half so the
                        // address never changes under an active write strobe.
                        if (GAP_EN && cnt_q == CNT_GAP) we_n_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_ready_d = 1'b0;
        unique case (state_q)
            IDLE:    mem_ready_d = ~(bus.rd_en | bus.wr_en);
            DONE:    mem_ready_d = 1'b1;
            default: mem_ready_d = 1'b0;
        endcase
    end

    assign bus.mem_ready = mem_ready_d;
    assign bus.read_data = read_data_q;

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed and randomized checks of sram_controller (ACCESS_CYCLES=2 and =1 builds)
// against word-level expectations and a behavioural 256K x 16 SRAM.
module tb_sram_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    sram_controller_if bus2 ();
    sram_controller_if bus1 ();

    wire  [15:0] dq2, dq1;
    logic [17:0] a2, a1;
    logic        we2, ub2, lb2, ce2, oe2;
    logic        we1, ub1, lb1, ce1, oe1;

    sram_controller #(.ACCESS_CYCLES(2), .BASE_ADDR(32'd1024)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .SRAM_DQ(dq2), .SRAM_ADDR(a2),
        .SRAM_WE_N(we2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2)
    );

    sram_controller #(.ACCESS_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .SRAM_DQ(dq1), .SRAM_ADDR(a1),
        .SRAM_WE_N(we1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
    );

    // Behavioural SRAM chips; each drives the bus only while a load is under way.
    logic [15:0] mem2 [0:262143];
    logic [15:0] mem1 [0:262143];
    bit moe2 = 1'b0;
    bit moe1 = 1'b0;

    assign dq2 = (moe2 && we2 && !oe2 && !ce2) ? mem2[a2] : 16'hzzzz;
    assign dq1 = (moe1 && we1 && !oe1 && !ce1) ? mem1[a1] : 16'hzzzz;

    always @(negedge clk) if (!we2 && !ce2) mem2[a2] <= dq2;
    always @(negedge clk) if (!we1 && !ce1) mem1[a1] <= dq1;

    // Undriven bus floats to all-ones so a released DQ is observable.
    for (genvar gi = 0; gi < 16; gi++) begin : g_pu
        pullup (dq2[gi]);
        pullup (dq1[gi]);
    end

    // Word-level reference contents, keyed by SRAM word index.
    logic [31:0] ref2 [int];
    logic [31:0] ref1 [int];

    function automatic int ref_word(input logic [31:0] a);
        return int'(((a - 32'd1024) / 4) % 131072);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel == 1) begin
            bus1.rd_en = rd; bus1.wr_en = wr; bus1.address = a; bus1.write_data = wd;
            moe1 = rd & ~wr;
        end else begin
            bus2.rd_en = rd; bus2.wr_en = wr; bus2.address = a; bus2.write_data = wd;
            moe2 = rd & ~wr;
        end
    endtask

    function automatic bit ready(input int sel);
        return (sel == 1) ? bus1.mem_ready : bus2.mem_ready;
    endfunction

    // Starts at a falling edge; cycle 0 is the cycle the request is first presented.
    task automatic access(input int sel, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input bit chain, input bit nrd, input bit nwr,
                          input logic [31:0] na, input logic [31:0] nwd,
                          output int lat, output logic [31:0] rdata);
        drive(sel, rd, wr, a, wd);
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ready(sel)) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        rdata = (sel == 1) ? bus1.read_data : bus2.read_data;
        if (chain) drive(sel, nrd, nwr, na, nwd);
        else       drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic op(input int sel, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] wd, input string tag);
        int          lat;
        int          w;
        int          n;
        logic [31:0] rv;
        logic [15:0] lo, hi;
        n = (sel == 1) ? 1 : 2;
        access(sel, rd, wr, a, wd, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, lat, rv);
        w = ref_word(a);
        chk({tag, "_latency"}, lat, 2 * n + 1);
        if (wr) begin
            if (sel == 1) ref1[w] = wd; else ref2[w] = wd;
            lo = (sel == 1) ? mem1[2 * w]     : mem2[2 * w];
            hi = (sel == 1) ? mem1[2 * w + 1] : mem2[2 * w + 1];
            chk({tag, "_sram_lo"}, 32'(lo), 32'(wd[15:0]));
            chk({tag, "_sram_hi"}, 32'(hi), 32'(wd[31:16]));
            $display("store sel=%0d addr=%0d data=%08h latency=%0d", sel, a, wd, lat);
        end else begin
            chk({tag, "_load"}, rv, (sel == 1) ? ref1[w] : ref2[w]);
            $display("load  sel=%0d addr=%0d data=%08h latency=%0d", sel, a, rv, lat);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rv;

        drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("reset_we_n",      32'(we2), 32'd1);
        chk("reset_addr",      32'(a2), 32'd0);
        chk("reset_dq_z",      32'(dq2), 32'h0000FFFF);
        chk("reset_read_data", bus2.read_data, 32'd0);
        chk("reset_ready",     32'(bus2.mem_ready), 32'd1);
        chk("tied_pins",       32'({ub2, lb2, ce2, oe2, ub1, lb1, ce1, oe1}), 32'd0);
        $display("reset released");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset during the low half of a write must release the bus at once.
        drive(2, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D);
        @(negedge clk);
        #1;
        chk("midwr_we_n_low", 32'(we2), 32'd0);
        chk("midwr_dq",       32'(dq2), 32'h0000F00D);
        #2 rst = 1'b1;
        #1;
        chk("rst_we_n_now", 32'(we2), 32'd1);
        chk("rst_dq_z_now", 32'(dq2), 32'h0000FFFF);
        drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rst_ready",     32'(bus2.mem_ready), 32'd1);
        chk("rst_read_data", bus2.read_data, 32'd0);
        $display("reset during write checked");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op(2, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, "store_base");
        op(2, 1'b1, 1'b0, 32'd1024, 32'd0, "load_base");
        #1 chk("load_hold_idle", bus2.read_data, 32'hDEADBEEF);

        op(2, 1'b0, 1'b1, 32'd1032, 32'h12345678, "map_1032");
        op(2, 1'b0, 1'b1, 32'd1035, 32'h9ABCDEF0, "map_1035");
        #1 chk("store_keeps_read_data", bus2.read_data, 32'hDEADBEEF);

        // Load chained straight into a store: second request waits in the IDLE after DONE.
        access(2, 1'b1, 1'b0, 32'd1024, 32'd0, 1'b1, 1'b0, 1'b1, 32'd1040, 32'h0BADC0DE, lat, rv);
        chk("b2b_load_latency", lat, 32'd5);
        chk("b2b_load_data",    rv, 32'hDEADBEEF);
        $display("load  sel=2 addr=1024 data=%08h latency=%0d (chained)", rv, lat);
        op(2, 1'b0, 1'b1, 32'd1040, 32'h0BADC0DE, "b2b_store");
        #1 chk("b2b_idle_ready", 32'(bus2.mem_ready), 32'd1);

        for (int w = 16; w < 32; w++)
            op(2, 1'b0, 1'b1, 32'(1024 + 4 * w + int'($urandom_range(0, 3))), $urandom, "fill");
        for (int i = 0; i < 24; i++) begin
            int          w;
            logic [31:0] a;
            w = int'($urandom_range(16, 31));
            a = 32'(1024 + 4 * w + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) op(2, 1'b1, 1'b0, a, 32'd0, "rand_load");
            else                           op(2, 1'b0, 1'b1, a, $urandom, "rand_store");
        end

        // Single-cycle halves; rd_en and wr_en together must perform a store.
        op(1, 1'b1, 1'b1, 32'd1100, 32'hA5A55A5A, "n1_rdwr_store");
        op(1, 1'b1, 1'b0, 32'd1100, 32'd0, "n1_load");
        op(1, 1'b0, 1'b1, 32'd2048, $urandom, "n1_store");
        op(1, 1'b1, 1'b0, 32'd2050, 32'd0, "n1_load2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the sequence ended");
        $fatal(1, "watchdog");
    end

endmodule
